// File: rtl/dm_wait_responder.sv
// -----------------------------------------------------------------------------
// dm_wait_responder
//   Responder end of the CPU data-memory port. This is a 1 KB word-organised
//   data memory that serves one load or store at a time over a valid/ready
//   request channel and a valid/ready response channel. A fixed number of wait
//   states is inserted between accepting a request and touching the memory.
//   It lets a multicycle or pipelined core be exercised against a slow memory.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (clears FSM, response, memory)
//   req_valid   request present
//   req_ready   responder idle and able to accept a request
//   req_we      1 = store word, 0 = load word
//   req_addr    byte address; word index = req_addr[ADDR_W-1:2]
//   req_wdata   store data
//   resp_valid  response present, held until resp_ready
//   resp_ready  requester accepts the response
//   resp_rdata  load data (0 for stores and misaligned requests)
//   resp_err    1 = misaligned address (req_addr[1:0] != 0)
// -----------------------------------------------------------------------------
module dm_wait_responder #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    // Counter must hold WAIT_CYCLES; keep at least one bit when it is zero.
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        mem [0:DEPTH_WORDS-1];

    logic               we_p0;
    logic [ADDR_W-1:0]  addr_p0;
    logic [31:0]        wdata_p0;

    logic               accept;
    logic               aligned;
    logic [ADDR_W-3:0]  widx;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign aligned   = (addr_p0[1:0] == 2'b00);
    assign widx      = addr_p0[ADDR_W-1:2];

    // Request capture: pure data, only meaningful once the FSM leaves IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // Control FSM, memory commit and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= WAIT_INIT;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Commit edge: the only place memory is written.
                        resp_valid <= 1'b1;
                        state      <= RESP;
                        if (!aligned) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else if (we_p0) begin
                            mem[widx]  <= wdata_p0;
                            resp_rdata <= '0;
                            resp_err   <= 1'b0;
                        end else begin
                            resp_rdata <= mem[widx];
                            resp_err   <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    // Response held stable; req_ready stays low on this edge.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_wait_responder.sv
module tb_dm_wait_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    // Instance A: WAIT_CYCLES=2
    logic        req_valid_a = 1'b0, req_we_a = 1'b0, resp_ready_a = 1'b0;
    logic [9:0]  req_addr_a  = '0;
    logic [31:0] req_wdata_a = '0;
    logic        req_ready_a, resp_valid_a, resp_err_a;
    logic [31:0] resp_rdata_a;

    // Instance B: WAIT_CYCLES=0
    logic        req_valid_b = 1'b0, req_we_b = 1'b0, resp_ready_b = 1'b0;
    logic [9:0]  req_addr_b  = '0;
    logic [31:0] req_wdata_b = '0;
    logic        req_ready_b, resp_valid_b, resp_err_b;
    logic [31:0] resp_rdata_b;

    int n_chk  = 0;
    int n_fail = 0;
    int last_acc = 0;

    dm_wait_responder #(.ADDR_W(10), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    dm_wait_responder #(.ADDR_W(10), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 400us");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    function automatic logic get_rv(input bit sel);
        return sel ? resp_valid_b : resp_valid_a;
    endfunction
    function automatic logic get_rdy(input bit sel);
        return sel ? req_ready_b : req_ready_a;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? resp_err_b : resp_err_a;
    endfunction
    function automatic logic [31:0] get_rd(input bit sel);
        return sel ? resp_rdata_b : resp_rdata_a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request at the sampling point; it is accepted on the next edge.
    task automatic issue(input bit sel, input logic we, input logic [9:0] addr,
                         input logic [31:0] wd, input string tag);
        chk({tag, "_rdy_idle"}, get_rdy(sel), 1);
        if (sel) begin
            req_valid_b = 1; req_we_b = we; req_addr_b = addr; req_wdata_b = wd;
        end else begin
            req_valid_a = 1; req_we_a = we; req_addr_a = addr; req_wdata_a = wd;
        end
        tick();
        last_acc = cyc;
        if (sel) req_valid_b = 0;
        else     req_valid_a = 0;
    endtask

    task automatic await_resp(input bit sel, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!get_rv(sel) && lat < 20);
    endtask

    task automatic ack(input bit sel);
        if (sel) resp_ready_b = 1;
        else     resp_ready_a = 1;
        tick();
        if (sel) resp_ready_b = 0;
        else     resp_ready_a = 0;
    endtask

    task automatic txn(input bit sel, input vec_t v, input int exp_lat, input string tag);
        int lat;
        issue(sel, v.we, v.addr, v.wdata, tag);
        await_resp(sel, lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rdata"}, get_rd(sel), v.exp_rdata);
        chk({tag, "_err"}, {31'd0, get_err(sel)}, {31'd0, v.exp_err});
        chk({tag, "_rdy_in_resp"}, get_rdy(sel), 0);
        ack(sel);
        chk({tag, "_vld_after_ack"}, get_rv(sel), 0);
        chk({tag, "_rdy_after_ack"}, get_rdy(sel), 1);
    endtask

    initial begin
        int lat;
        int acc0;
        vec_t v;

        vecs[0] = '{1'b1, 10'h004, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 10'h006, 32'h12345678, 32'h0,        1'b1};
        vecs[3] = '{1'b0, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[4] = '{1'b0, 10'h000, 32'h0,        32'h0,        1'b0};
        vecs[5] = '{1'b0, 10'h005, 32'h0,        32'h0,        1'b1};
        vecs[6] = '{1'b1, 10'h3FC, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[7] = '{1'b0, 10'h3FC, 32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[8] = '{1'b0, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0};

        // Initial reset
        repeat (3) tick();
        chk("por_rdy", req_ready_a, 1);
        chk("por_vld", resp_valid_a, 0);
        chk("por_rdata", resp_rdata_a, 0);
        rst = 0;
        tick();

        // Mid-cycle reset while a response with data is pending
        v = '{1'b1, 10'h010, 32'h000055AA, 32'h0, 1'b0};
        txn(0, v, 3, "pre_store");
        issue(0, 1'b0, 10'h010, 32'h0, "pre_load");
        await_resp(0, lat);
        chk("pre_load_rdata", resp_rdata_a, 32'h000055AA);
        #2;
        rst = 1;
        #1;
        chk("async_rst_rdy", req_ready_a, 1);
        chk("async_rst_vld", resp_valid_a, 0);
        chk("async_rst_rdata", resp_rdata_a, 0);
        tick();
        rst = 0;
        tick();
        v = '{1'b0, 10'h000, 32'h0, 32'h0, 1'b0};
        txn(0, v, 3, "rst_load0");
        v = '{1'b0, 10'h010, 32'h0, 32'h0, 1'b0};
        txn(0, v, 3, "rst_load10");

        // Table-driven transactions on the 2-wait-state instance
        for (int i = 0; i < 9; i++) begin
            txn(0, vecs[i], 3, $sformatf("vec%0d", i));
        end

        // Backpressure: hold response for 5 cycles, with a stray request
        issue(0, 1'b0, 10'h004, 32'h0, "hold");
        await_resp(0, lat);
        chk("hold_latency", lat, 3);
        req_valid_a = 1; req_we_a = 1; req_addr_a = 10'h004; req_wdata_a = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_vld", i), resp_valid_a, 1);
            chk($sformatf("hold%0d_rdata", i), resp_rdata_a, 32'hDEADBEEF);
            chk($sformatf("hold%0d_rdy", i), req_ready_a, 0);
            tick();
        end
        req_valid_a = 0;
        ack(0);
        chk("hold_release_vld", resp_valid_a, 0);
        chk("hold_release_rdy", req_ready_a, 1);
        v = '{1'b0, 10'h004, 32'h0, 32'hDEADBEEF, 1'b0};
        txn(0, v, 3, "after_hold");

        // Reset before commit drops the store and any response
        issue(0, 1'b1, 10'h3FC, 32'hCAFEF00D, "abort");
        tick();
        rst = 1;
        #1;
        chk("abort_vld_in_rst", resp_valid_a, 0);
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("abort_noresp%0d", i), resp_valid_a, 0);
        end
        v = '{1'b0, 10'h3FC, 32'h0, 32'h0, 1'b0};
        txn(0, v, 3, "abort_load");

        // Zero wait states: back-to-back accesses on the last word
        v = '{1'b1, 10'h3FC, 32'h0BADF00D, 32'h0, 1'b0};
        txn(1, v, 1, "w0_store");
        acc0 = last_acc;
        v = '{1'b0, 10'h3FC, 32'h0, 32'h0BADF00D, 1'b0};
        txn(1, v, 1, "w0_load");
        chk("w0_spacing", last_acc - acc0, 3);
        acc0 = last_acc;
        v = '{1'b1, 10'h000, 32'h76543210, 32'h0, 1'b0};
        txn(1, v, 1, "w0_store0");
        chk("w0_spacing2", last_acc - acc0, 3);
        v = '{1'b0, 10'h000, 32'h0, 32'h76543210, 1'b0};
        txn(1, v, 1, "w0_load0");
        v = '{1'b0, 10'h3FC, 32'h0, 32'h0BADF00D, 1'b0};
        txn(1, v, 1, "w0_reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
